// File: rtl/mips_ctrl_pkg.sv
// Shared constants for the multicycle MIPS control sequencer: opcodes,
// state encodings, ALU / mux select encodings and the control bundle type.
package mips_ctrl_pkg;

    // Supported opcodes (IR[31:26])
    localparam logic [5:0] R_TYPE = 6'h00;
    localparam logic [5:0] J      = 6'h02;
    localparam logic [5:0] BEQ    = 6'h04;
    localparam logic [5:0] BNE    = 6'h05;
    localparam logic [5:0] ADDI   = 6'h08;
    localparam logic [5:0] ORI    = 6'h0D;
    localparam logic [5:0] LW     = 6'h23;
    localparam logic [5:0] SW     = 6'h2B;

    // Sequencer states; the encoding is also exported on state_out
    localparam logic [3:0] IDLE      = 4'd0;
    localparam logic [3:0] FETCH     = 4'd1;
    localparam logic [3:0] DECODE    = 4'd2;
    localparam logic [3:0] MEM_ADDR  = 4'd3;
    localparam logic [3:0] MEM_READ  = 4'd4;
    localparam logic [3:0] MEM_WB    = 4'd5;
    localparam logic [3:0] MEM_WRITE = 4'd6;
    localparam logic [3:0] EXEC_R    = 4'd7;
    localparam logic [3:0] R_WB      = 4'd8;
    localparam logic [3:0] EXEC_I    = 4'd9;
    localparam logic [3:0] I_WB      = 4'd10;
    localparam logic [3:0] BRANCH    = 4'd11;
    localparam logic [3:0] JUMP      = 4'd12;

    // ALU operation classes
    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_FUNCT = 3'b010;
    localparam logic [2:0] ALU_OR    = 3'b011;

    // ALU B operand select
    localparam logic [1:0] SRCB_RT      = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    // PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Opcode class latched in DECODE; steers the later states
    typedef enum logic [2:0] {
        CLS_R, CLS_LW, CLS_SW, CLS_ADDI, CLS_ORI, CLS_BEQ, CLS_BNE, CLS_J
    } op_class_t;

    // All datapath controls driven by the sequencer
    typedef struct packed {
        logic       pc_write;
        logic       branch_eq;
        logic       branch_ne;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_t;

    function automatic logic op_legal(input logic [5:0] op);
        return op inside {R_TYPE, J, BEQ, BNE, ADDI, ORI, LW, SW};
    endfunction

    // Illegal opcodes map to CLS_R; callers gate on op_legal()
    function automatic op_class_t op_class(input logic [5:0] op);
        op_class_t cls;
        case (op)
            LW:      cls = CLS_LW;
            SW:      cls = CLS_SW;
            ADDI:    cls = CLS_ADDI;
            ORI:     cls = CLS_ORI;
            BEQ:     cls = CLS_BEQ;
            BNE:     cls = CLS_BNE;
            J:       cls = CLS_J;
            default: cls = CLS_R;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/ctrl_output_decode.sv
// Moore output decode: control bundle from current state, latched opcode
// class and mem_ready (the latter only matters in FETCH).
module ctrl_output_decode
    import mips_ctrl_pkg::*;
(
    input  logic [3:0] state,
    input  op_class_t  cls,
    input  logic       mem_ready,
    output ctrl_t      ctrl
);

    // Per-state control values; anything not named for a state stays 0
    always_comb begin
        // NOTE: zero the whole bundle first so every path assigns every bit and no latch is inferred.
        ctrl = '0;
        case (state)
            FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALU_ADD;
                ctrl.pc_source = PCSRC_ALU;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            DECODE: begin
                ctrl.alu_src_b = SRCB_IMM_SH2;
                ctrl.alu_op    = ALU_ADD;
            end
            MEM_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_ADD;
            end
            MEM_READ: begin
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
            end
            MEM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            MEM_WRITE: begin
                ctrl.mem_write = 1'b1;
                ctrl.iord      = 1'b1;
            end
            EXEC_R: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_RT;
                ctrl.alu_op    = ALU_FUNCT;
            end
            R_WB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            EXEC_I: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = (cls == CLS_ORI) ? ALU_OR : ALU_ADD;
            end
            I_WB: begin
                ctrl.reg_write = 1'b1;
            end
            BRANCH: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_RT;
                ctrl.alu_op    = ALU_SUB;
                ctrl.pc_source = PCSRC_ALUOUT;
                ctrl.branch_eq = (cls == CLS_BEQ);
                ctrl.branch_ne = (cls == CLS_BNE);
            end
            JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle MIPS control sequencer: state register, opcode class latch,
// retired-instruction counter and sticky illegal-opcode flag.
module multicycle_control_fsm
    import mips_ctrl_pkg::*;
#(
    parameter int OPCODE_W = 6,
    parameter int COUNT_W  = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [OPCODE_W-1:0] OP,
    input  logic               mem_ready,
    output logic               PCWrite,
    output logic               BranchEQ,
    output logic               BranchNE,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               MemtoReg,
    output logic               RegDst,
    output logic               RegWrite,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [2:0]         ALUOp,
    output logic [1:0]         PCSource,
    output logic [3:0]         state_out,
    output logic [COUNT_W-1:0] instr_count,
    output logic               illegal_op
);

    logic [3:0] state_q;
    logic [3:0] state_d;
    op_class_t  cls_q;
    op_class_t  dec_cls;
    logic       dec_legal;
    logic       retire;
    ctrl_t      ctrl;

    assign dec_legal = op_legal(OP);
    assign dec_cls   = op_class(OP);

    // Next-state selection and retire strobe (set on the final state's exit)
    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        case (state_q)
            IDLE:      state_d = FETCH;
            FETCH:     if (mem_ready) state_d = DECODE;
            DECODE: begin
                if (!dec_legal) begin
                    state_d = FETCH;
                end else begin
                    case (dec_cls)
                        CLS_R:            state_d = EXEC_R;
                        CLS_LW, CLS_SW:   state_d = MEM_ADDR;
                        CLS_ADDI, CLS_ORI: state_d = EXEC_I;
                        CLS_BEQ, CLS_BNE: state_d = BRANCH;
                        CLS_J:            state_d = JUMP;
                        default:          state_d = FETCH;
                    endcase
                end
            end
            MEM_ADDR:  state_d = (cls_q == CLS_SW) ? MEM_WRITE : MEM_READ;
            MEM_READ:  if (mem_ready) state_d = MEM_WB;
            MEM_WRITE: begin
                if (mem_ready) begin
                    state_d = FETCH;
                    retire  = 1'b1;
                end
            end
            EXEC_R:    state_d = R_WB;
            EXEC_I:    state_d = I_WB;
            MEM_WB, R_WB, I_WB, BRANCH, JUMP: begin
                state_d = FETCH;
                retire  = 1'b1;
            end
            default:   state_d = FETCH;
        endcase
    end

    // State, opcode class, retire counter and illegal flag registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cls_q       <= CLS_R;
            instr_count <= '0;
            illegal_op  <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every register samples pre-edge values regardless of statement order.
            state_q <= state_d;
            if (state_q == DECODE) begin
                cls_q <= dec_cls;
                if (!dec_legal) illegal_op <= 1'b1;
            end
            if (retire) instr_count <= instr_count + COUNT_W'(1);
        end
    end

    ctrl_output_decode u_decode (
        .state     (state_q),
        .cls       (cls_q),
        .mem_ready (mem_ready),
        .ctrl      (ctrl)
    );

    assign PCWrite   = ctrl.pc_write;
    assign BranchEQ  = ctrl.branch_eq;
    assign BranchNE  = ctrl.branch_ne;
    assign IorD      = ctrl.iord;
    assign MemRead   = ctrl.mem_read;
    assign MemWrite  = ctrl.mem_write;
    assign IRWrite   = ctrl.ir_write;
    assign MemtoReg  = ctrl.mem_to_reg;
    assign RegDst    = ctrl.reg_dst;
    assign RegWrite  = ctrl.reg_write;
    assign ALUSrcA   = ctrl.alu_src_a;
    assign ALUSrcB   = ctrl.alu_src_b;
    assign ALUOp     = ctrl.alu_op;
    assign PCSource  = ctrl.pc_source;
    assign state_out = state_q;

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
Moore-style control sequencer for a multicycle variant of the team's MIPS core. The datapath shares one memory for instructions and data, and one ALU for PC increment, branch target and execution. This block steps each instruction through fetch, decode, execute, memory and writeback. It drives every datapath enable and mux select, and handshakes with the shared memory port.

Parameters:
OPCODE_W, 6, width of the instruction opcode field
COUNT_W, 32, width of the retired-instruction counter

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
OP  input  6  opcode, IR[31:26], from the instruction register
mem_ready  input  1  shared memory has completed the current access this cycle
PCWrite  output  1  unconditional PC load
BranchEQ  output  1  PC load if ALU Zero=1
BranchNE  output  1  PC load if ALU Zero=0
IorD  output  1  memory address select: 0=PC, 1=ALUOut
MemRead  output  1  memory read request
MemWrite  output  1  memory write request
IRWrite  output  1  instruction register load
MemtoReg  output  1  register write data select: 0=ALUOut, 1=MDR
RegDst  output  1  write register select: 0=rt, 1=rd
RegWrite  output  1  register file write enable
ALUSrcA  output  1  ALU A select: 0=PC, 1=rs data
ALUSrcB  output  2  ALU B select: 00=rt, 01=const 4, 10=signext imm, 11=signext imm<<2
ALUOp  output  3  ALU operation class: ADD, SUB, FUNCT, OR
PCSource  output  2  PC source: 00=ALU result, 01=ALUOut, 10=jump target
state_out  output  4  current state encoding, for debug
instr_count  output  COUNT_W  number of retired instructions
illegal_op  output  1  sticky flag: an unsupported opcode was decoded

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, instr_count=0, illegal_op=0.
  - All control outputs are 0 in IDLE.
  - IDLE lasts exactly one cycle after reset deasserts, then the FSM goes to FETCH.
- Outputs are decoded only from the state register and mem_ready. Any signal not listed for a state is 0.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=ADD, PCSource=00.
  - IRWrite and PCWrite equal mem_ready.
  - Stays in FETCH while mem_ready=0. Goes to DECODE on mem_ready=1.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=ADD (branch target into ALUOut). Next state by OP:
  - 0x00 -> EXEC_R
  - 0x23 or 0x2B -> MEM_ADDR
  - 0x08 -> EXEC_I with ADD
  - 0x0D -> EXEC_I with OR
  - 0x04 or 0x05 -> BRANCH
  - 0x02 -> JUMP
  - Any other opcode: illegal_op is set (sticky until reset), the instruction is not retired, next state is FETCH.
- EXEC_I ALU operation: the opcode class is latched in DECODE.
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=ADD. Goes to MEM_READ for lw, MEM_WRITE for sw.
- MEM_READ: MemRead=1, IorD=1. Waits for mem_ready=1, then goes to MEM_WB.
- MEM_WB: RegWrite=1, MemtoReg=1, RegDst=0. Retires; goes to FETCH.
- MEM_WRITE: MemWrite=1, IorD=1. Waits for mem_ready=1, then retires and goes to FETCH.
- EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUOp=FUNCT. Goes to R_WB.
- R_WB: RegWrite=1, RegDst=1, MemtoReg=0. Retires; goes to FETCH.
- EXEC_I: ALUSrcA=1, ALUSrcB=10, ALUOp=ADD (addi) or OR (ori). Goes to I_WB.
- I_WB: RegWrite=1, RegDst=0, MemtoReg=0. Retires; goes to FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=SUB, PCSource=01. BranchEQ=1 for 0x04, BranchNE=1 for 0x05. Retires; goes to FETCH.
- JUMP: PCWrite=1, PCSource=10. Retires; goes to FETCH.
- Cycles per instruction with zero memory wait:
  - lw 5
  - sw, R-type, addi, ori 4
  - beq, bne, j 3
- Retire rule: instr_count increments by 1 on the cycle the instruction leaves its final state. It wraps modulo 2^COUNT_W.
- Memory requests: MemRead and MemWrite are never both 1. Each is held steady until mem_ready; the request deasserts the cycle after mem_ready.
- mem_ready outside FETCH, MEM_READ and MEM_WRITE is ignored.
- Unused state encodings go to FETCH.
- Reset asserted mid-instruction: the instruction is abandoned immediately and no write strobe is issued after reset.

Decomposition:
- Shared package mips_ctrl_pkg holds:
  - opcode constants (R_TYPE, ADDI, ORI, LW, SW, BEQ, BNE, J)
  - the 4-bit state encodings
  - the ALUOp class constants ADD=000, SUB=001, FUNCT=010, OR=011
  - the ALUSrcB and PCSource encodings
- One natural sub-module, ctrl_output_decode: a purely combinational decode from state, latched opcode class and mem_ready to the control outputs.
- The state register, retire counter and illegal flag stay in the top module.

Test Plan:
- Reset, then mem_ready tied to 1, OP=0x00: states IDLE, FETCH, DECODE, EXEC_R, R_WB, FETCH. RegDst=1 and RegWrite=1 only in R_WB. instr_count=1 after 5 cycles.
- OP=0x23, mem_ready low for 3 cycles in MEM_READ: MemRead=1 and IorD=1 held for 4 cycles. MEM_WB asserts MemtoReg=1, RegWrite=1. instr_count increments once.
- OP=0x2B: MEM_WRITE asserts MemWrite=1 with IorD=1 and RegWrite=0 throughout. FSM returns to FETCH after 4 cycles.
- OP=0x04, then 0x05: in BRANCH, BranchEQ=1/BranchNE=0, then BranchEQ=0/BranchNE=1. ALUOp=SUB, PCSource=01. 3 cycles each.
- OP=0x3F: illegal_op rises in DECODE and stays 1. instr_count is unchanged. Next state is FETCH. A following OP=0x08 executes normally.
- Assert reset during MEM_WRITE with mem_ready=0: MemWrite drops within the same cycle. state=IDLE, instr_count=0, illegal_op=0.
